// File: rtl/gem_event_pkg.sv
// Shared types for the GEM event queue: kind encoding, field widths and the
// FIFO entry layout. Optional feature macro: GEM_EVENT_TIMESTAMP_EN adds a
// per-event 32-bit cycle timestamp to every entry.
package gem_event_pkg;

  localparam int CH_W = 4;
  localparam int ID_W = 32;
  localparam int TS_W = 32;

  typedef enum logic {
    KIND_ASSERT  = 1'b0,
    KIND_DISPLAY = 1'b1
  } gem_event_kind_e;

  typedef struct packed {
    gem_event_kind_e   kind;
    logic [CH_W-1:0]   ch;
    logic [ID_W-1:0]   id;
`ifdef GEM_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } gem_event_entry_t;

endpackage

// File: rtl/gem_event_queue_if.sv
// Output event stream of the GEM event queue (valid/ready, first-word-fall-through).
// Optional feature macro: GEM_EVENT_TIMESTAMP_EN adds OUT_TIME.
interface gem_event_queue_if;
  import gem_event_pkg::*;

  logic            OUT_VALID;
  logic            OUT_READY;
  logic            OUT_KIND;
  logic [CH_W-1:0] OUT_CH;
  logic [ID_W-1:0] OUT_ID;
`ifdef GEM_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] OUT_TIME;
`endif

  modport master (
    input  OUT_READY,
    output OUT_VALID, OUT_KIND, OUT_CH, OUT_ID
`ifdef GEM_EVENT_TIMESTAMP_EN
    , OUT_TIME
`endif
  );

  modport slave (
    output OUT_READY,
    input  OUT_VALID, OUT_KIND, OUT_CH, OUT_ID
`ifdef GEM_EVENT_TIMESTAMP_EN
    , OUT_TIME
`endif
  );

endinterface

// File: rtl/gem_event_fifo.sv
// Event FIFO with first-word-fall-through head. A push is accepted when not
// full, or when full together with a pop. Head reads as all-zero when empty
// so the outputs sit at 0 after reset.
module gem_event_fifo
  import gem_event_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = gem_event_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and count state; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset because the count gates the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/gem_event_queue.sv
// GEM event queue: captures assertion failures and display triggers into
// per-channel pending slots, moves one per cycle into the event FIFO by fixed
// priority (asserts before displays, low index first) and presents the head on
// a valid/ready stream. Optional feature macro: GEM_EVENT_TIMESTAMP_EN adds a
// free-running cycle counter whose value at the fire edge travels with each event.
module gem_event_queue
  import gem_event_pkg::*;
#(
  parameter int NA    = 4,
  parameter int ND    = 4,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NA-1:0]    ASSERT_EN,
  input  logic [NA-1:0]    ASSERT_A,
  input  logic [ND-1:0]    DISP_EN,
  input  logic [32*ND-1:0] DISP_MSG_ID,
  output logic [15:0]      DROP_CNT,
  output logic             FAIL_SEEN,
  gem_event_queue_if.master out_if
);

  localparam int N = NA + ND;

  logic [N-1:0]      fire;
  logic [N-1:0]      pend_q, pend_d;
  gem_event_entry_t  pay_q [N];
  gem_event_entry_t  pay_d [N];
  gem_event_entry_t  new_ent [N];
  logic [N-1:0]      gnt, xfer;
  logic              arb_found;
  gem_event_entry_t  xfer_ent, head;
  logic              push, pop, fifo_full, fifo_empty;
  logic [5:0]        ndrop;
  logic [16:0]       drop_sum;
  logic [15:0]       drop_q, drop_d;
  logic              fail_q, fail_d;
`ifdef GEM_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0]   cyc_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_assert_fire
      assign fire[gi] = ASSERT_EN[gi] & ~ASSERT_A[gi];
    end
    for (gi = 0; gi < ND; gi++) begin : g_disp_fire
      assign fire[NA+gi] = DISP_EN[gi];
    end
  endgenerate

  // Payload each channel would capture if it fires this cycle.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      new_ent[k] = '0;
      if (k < NA) begin
        new_ent[k].kind = KIND_ASSERT;
        new_ent[k].ch   = CH_W'(k);
      end else begin
        new_ent[k].kind = KIND_DISPLAY;
        new_ent[k].ch   = CH_W'(k - NA);
        new_ent[k].id   = DISP_MSG_ID[32*(k-NA) +: 32];
      end
`ifdef GEM_EVENT_TIMESTAMP_EN
      new_ent[k].ts = cyc_q;
`endif
    end
  end

  // Fixed-priority grant: lowest pending index wins (asserts occupy the low indices).
  always_comb begin
    gnt       = '0;
    arb_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (pend_q[k] && !arb_found) begin
        gnt[k]    = 1'b1;
        arb_found = 1'b1;
      end
    end
  end

  assign pop  = out_if.OUT_VALID & out_if.OUT_READY;
  assign push = (|pend_q) & (~fifo_full | pop);
  assign xfer = gnt & {N{push}};

  // Select the granted slot's payload for the FIFO write.
  always_comb begin
    xfer_ent = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) begin
        xfer_ent = pay_q[k];
      end
    end
  end

  // Pending-slot update: a fire lands in a free or just-drained slot, otherwise it is dropped.
  always_comb begin
    pend_d = pend_q;
    ndrop  = '0;
    for (int k = 0; k < N; k++) begin
      pay_d[k] = pay_q[k];
      if (fire[k] && (!pend_q[k] || xfer[k])) begin
        pend_d[k] = 1'b1;
        pay_d[k]  = new_ent[k];
      end else if (fire[k]) begin
        ndrop = ndrop + 6'd1;
      end else if (xfer[k]) begin
        pend_d[k] = 1'b0;
      end
    end
    drop_sum = {1'b0, drop_q} + {11'd0, ndrop};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    fail_d   = fail_q | (|fire[NA-1:0]);
  end

  // Pending slots, drop counter and sticky failure flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q <= '0;
      drop_q <= '0;
      fail_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        pay_q[k] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      fail_q <= fail_d;
      for (int k = 0; k < N; k++) begin
        pay_q[k] <= pay_d[k];
      end
    end
  end

`ifdef GEM_EVENT_TIMESTAMP_EN
  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
    end
  end
`endif

  gem_event_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (gem_event_entry_t)
  ) u_fifo (
    .clk         (CLK),
    .rst         (RST),
    .push_i      (push),
    .push_data_i (xfer_ent),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign out_if.OUT_VALID = ~fifo_empty;
  assign out_if.OUT_KIND  = head.kind;
  assign out_if.OUT_CH    = head.ch;
  assign out_if.OUT_ID    = head.id;
`ifdef GEM_EVENT_TIMESTAMP_EN
  assign out_if.OUT_TIME  = head.ts;
`endif
  assign DROP_CNT  = drop_q;
  assign FAIL_SEEN = fail_q;

endmodule

// File: tb/tb_gem_event_queue.sv
// Scoreboard bench for gem_event_queue: stimulus pushes expected events, a
// negedge monitor pops and compares every accepted output event.
module tb_gem_event_queue;

  localparam int NA = 4;
  localparam int ND = 4;
  localparam int DEPTH = 16;

  logic             CLK;
  logic             RST;
  logic [NA-1:0]    ASSERT_EN;
  logic [NA-1:0]    ASSERT_A;
  logic [ND-1:0]    DISP_EN;
  logic [32*ND-1:0] DISP_MSG_ID;
  logic [15:0]      DROP_CNT;
  logic             FAIL_SEEN;

  gem_event_queue_if bus();

  gem_event_queue #(.NA(NA), .ND(ND), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ASSERT_EN   (ASSERT_EN),
    .ASSERT_A    (ASSERT_A),
    .DISP_EN     (DISP_EN),
    .DISP_MSG_ID (DISP_MSG_ID),
    .DROP_CNT    (DROP_CNT),
    .FAIL_SEEN   (FAIL_SEEN),
    .out_if      (bus.master)
  );

  typedef struct {
    logic        kind;
    logic [3:0]  ch;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] tb_cyc;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference cycle count: value in effect when a fire is sampled.
  always @(posedge CLK or posedge RST) begin
    if (RST) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic kind, input logic [3:0] ch, input logic [31:0] id,
                          input logic [31:0] ts);
    exp_t e;
    e.kind = kind; e.ch = ch; e.id = id; e.ts = ts;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every accepted output event is compared against the scoreboard head.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && bus.OUT_VALID && bus.OUT_READY) begin
      $display("EVT kind=%0d ch=%0d id=%h", bus.OUT_KIND, bus.OUT_CH, bus.OUT_ID);
      if (sb_q.size() == 0) begin
        chk("unexpected_event", {31'd0, bus.OUT_VALID}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("evt_kind", {31'd0, bus.OUT_KIND}, {31'd0, e.kind});
        chk("evt_ch", {28'd0, bus.OUT_CH}, {28'd0, e.ch});
        chk("evt_id", bus.OUT_ID, e.id);
`ifdef GEM_EVENT_TIMESTAMP_EN
        chk("evt_time", bus.OUT_TIME, e.ts);
`endif
      end
    end
  end

  initial begin
    RST = 1'b1;
    ASSERT_EN = '0;
    ASSERT_A = '1;
    DISP_EN = '0;
    DISP_MSG_ID = '0;
    bus.OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("rst_kind", {31'd0, bus.OUT_KIND}, 32'd0);
    chk("rst_ch", {28'd0, bus.OUT_CH}, 32'd0);
    chk("rst_id", bus.OUT_ID, 32'd0);
    chk("rst_drop", {16'd0, DROP_CNT}, 32'd0);
    chk("rst_fail", {31'd0, FAIL_SEEN}, 32'd0);

    // Single assert fire on channel 2, two-cycle latency
    bus.OUT_READY = 1'b1;
    ASSERT_EN[2] = 1'b1; ASSERT_A[2] = 1'b0;
    push_exp(1'b0, 4'd2, 32'd0, tb_cyc);
    tick();
    ASSERT_EN = '0; ASSERT_A = '1;
    chk("lat_valid_t", {31'd0, bus.OUT_VALID}, 32'd0);
    tick();
    chk("lat_valid_t1", {31'd0, bus.OUT_VALID}, 32'd1);
    tick();
    chk("lat_valid_t2", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("fail_seen", {31'd0, FAIL_SEEN}, 32'd1);

    // Priority: assert ch3 beats display ch0 fired in the same cycle
    ASSERT_EN[3] = 1'b1; ASSERT_A[3] = 1'b0;
    DISP_EN[0] = 1'b1; DISP_MSG_ID[31:0] = 32'h0000_1234;
    push_exp(1'b0, 4'd3, 32'd0, tb_cyc);
    push_exp(1'b1, 4'd0, 32'h0000_1234, tb_cyc);
    tick();
    ASSERT_EN = '0; ASSERT_A = '1; DISP_EN = '0;
    repeat (5) tick();
    chk("prio_drained", 32'(sb_q.size()), 32'd0);

    // Full FIFO: 20 fires on display ch1 with no consumer -> 17 kept, 3 dropped
    bus.OUT_READY = 1'b0;
    for (int n = 0; n < 20; n++) begin
      DISP_EN[1] = 1'b1;
      DISP_MSG_ID[63:32] = 32'h100 + 32'(n);
      if (n < 17) push_exp(1'b1, 4'd1, 32'h100 + 32'(n), tb_cyc);
      tick();
    end
    DISP_EN = '0;
    tick();
    chk("full_drop_cnt", {16'd0, DROP_CNT}, 32'd3);
    chk("full_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    chk("full_head_id", bus.OUT_ID, 32'h100);
    bus.OUT_READY = 1'b1;
    repeat (22) tick();
    chk("full_drained", 32'(sb_q.size()), 32'd0);
    chk("full_empty", {31'd0, bus.OUT_VALID}, 32'd0);

    // Refire on transfer: two back-to-back fires on display ch0, no drop
    DISP_EN[0] = 1'b1; DISP_MSG_ID[31:0] = 32'h0000_000A;
    push_exp(1'b1, 4'd0, 32'h0000_000A, tb_cyc);
    tick();
    DISP_MSG_ID[31:0] = 32'h0000_000B;
    push_exp(1'b1, 4'd0, 32'h0000_000B, tb_cyc);
    tick();
    DISP_EN = '0;
    repeat (4) tick();
    chk("refire_drained", 32'(sb_q.size()), 32'd0);
    chk("refire_drop_cnt", {16'd0, DROP_CNT}, 32'd3);

    // Reset mid-stream with 5 queued events
    bus.OUT_READY = 1'b0;
    for (int n = 0; n < 5; n++) begin
      DISP_EN[2] = 1'b1;
      DISP_MSG_ID[95:64] = 32'h200 + 32'(n);
      tick();
    end
    DISP_EN = '0;
    repeat (2) tick();
    chk("mid_valid_before", {31'd0, bus.OUT_VALID}, 32'd1);
    #2;
    RST = 1'b1;
    sb_q.delete();
    #1;
    chk("mid_valid_rst", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("mid_drop_rst", {16'd0, DROP_CNT}, 32'd0);
    chk("mid_fail_rst", {31'd0, FAIL_SEEN}, 32'd0);
    // A fire held while reset is high across edges must not be captured
    DISP_EN[0] = 1'b1; DISP_MSG_ID[31:0] = 32'h0000_0077;
    repeat (2) tick();
    #2;
    RST = 1'b0;
    DISP_EN = '0;

    // Timestamp vector: fires sampled at cycles 10 and 11 after reset release
    repeat (10) tick();
    chk("rst_no_capture", {31'd0, bus.OUT_VALID}, 32'd0);
    bus.OUT_READY = 1'b1;
    DISP_EN[3] = 1'b1; DISP_MSG_ID[127:96] = 32'h0000_0055;
    push_exp(1'b1, 4'd3, 32'h0000_0055, 32'd10);
    tick();
    DISP_MSG_ID[127:96] = 32'h0000_0066;
    push_exp(1'b1, 4'd3, 32'h0000_0066, 32'd11);
    tick();
    DISP_EN = '0;
    repeat (4) tick();
    chk("ts_drained", 32'(sb_q.size()), 32'd0);
    chk("ts_drop_cnt", {16'd0, DROP_CNT}, 32'd0);
    chk("ts_fail", {31'd0, FAIL_SEEN}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
